// File: rtl/ring_router_param.sv
// ring_router_param: ring stop with cw/ccw/PE inputs and two VC-phase buffers per input.
// Latency: one cycle from a buffer write to the registered output pulse when the output is ready and uncontended.
// Backpressure: an input's ready drops when its current-phase buffer is full; a stalled head waits for a later cycle of the same phase.
// Optional feature macro: RING_ROUTER_RR_ARB_EN selects round-robin arbitration (fixed priority otherwise).

// Small synchronous FIFO with a combinational head. Pushes to a full FIFO
// and pops from an empty FIFO are ignored.
module ring_router_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      ptr_one;

    assign ptr_one  = {{AW{1'b0}}, 1'b1};
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    // Read/write pointers; the extra MSB tells full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + ptr_one;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + ptr_one;
            end
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end
endmodule

module ring_router_param #(
    parameter int PAC_WIDTH = 64,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 polarity,
    input  logic                 cwsi,
    input  logic                 ccwsi,
    input  logic                 pesi,
    output logic                 cwri,
    output logic                 ccwri,
    output logic                 peri,
    input  logic [PAC_WIDTH-1:0] cwdi,
    input  logic [PAC_WIDTH-1:0] ccwdi,
    input  logic [PAC_WIDTH-1:0] pedi,
    output logic                 cwso,
    output logic                 ccwso,
    output logic                 peso,
    input  logic                 cwro,
    input  logic                 ccwro,
    input  logic                 pero,
    output logic [PAC_WIDTH-1:0] cwdo,
    output logic [PAC_WIDTH-1:0] ccwdo,
    output logic [PAC_WIDTH-1:0] pedo
);
    // Port index used for both inputs and outputs.
    localparam int CW  = 0;
    localparam int CCW = 1;
    localparam int PE  = 2;

    localparam int DIR_BIT = PAC_WIDTH - 2;

    function automatic logic [7:0] hop_of(input logic [PAC_WIDTH-1:0] p);
        return p[PAC_WIDTH-9 -: 8];
    endfunction

    // Ring-to-ring forwarding consumes one hop; only called for hop != 0.
    function automatic logic [PAC_WIDTH-1:0] dec_hop(input logic [PAC_WIDTH-1:0] p);
        logic [PAC_WIDTH-1:0] r;
        r = p;
        r[PAC_WIDTH-9 -: 8] = p[PAC_WIDTH-9 -: 8] - 8'd1;
        return r;
    endfunction

    logic [2:0]           in_send;
    logic [PAC_WIDTH-1:0] in_dat [3];
    logic [2:0]           in_rdy;
    logic [2:0]           out_rdy;
    logic [2:0]           out_vld;
    logic [PAC_WIDTH-1:0] out_dat [3];

    assign in_send = {pesi, ccwsi, cwsi};
    assign in_dat[CW]  = cwdi;
    assign in_dat[CCW] = ccwdi;
    assign in_dat[PE]  = pedi;
    assign out_rdy = {pero, ccwro, cwro};

    assign cwri  = in_rdy[CW];
    assign ccwri = in_rdy[CCW];
    assign peri  = in_rdy[PE];
    assign cwso  = out_vld[CW];
    assign ccwso = out_vld[CCW];
    assign peso  = out_vld[PE];
    assign cwdo  = out_dat[CW];
    assign ccwdo = out_dat[CCW];
    assign pedo  = out_dat[PE];

    // Per input, per phase buffer status.
    logic [2:0][1:0]      fifo_push;
    logic [2:0][1:0]      fifo_pop;
    logic [2:0][1:0]      fifo_full;
    logic [2:0][1:0]      fifo_empty;
    logic [PAC_WIDTH-1:0] fifo_head [3][2];
    logic [2:0]           src_pop;

    // The external side writes buf[polarity]; the router drains buf[~polarity].
    for (genvar gi = 0; gi < 3; gi++) begin : g_in
        assign in_rdy[gi] = !fifo_full[gi][polarity] && !reset;
        for (genvar gb = 0; gb < 2; gb++) begin : g_buf
            localparam logic PHASE = (gb != 0);
            assign fifo_push[gi][gb] = in_send[gi] && in_rdy[gi] && (polarity == PHASE);
            assign fifo_pop[gi][gb]  = src_pop[gi] && (polarity != PHASE);
            ring_router_fifo #(
                .WIDTH (PAC_WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk      (clk),
                .reset    (reset),
                .push     (fifo_push[gi][gb]),
                .push_dat (in_dat[gi]),
                .pop      (fifo_pop[gi][gb]),
                .head_dat (fifo_head[gi][gb]),
                .full     (fifo_full[gi][gb]),
                .empty    (fifo_empty[gi][gb])
            );
        end
    end

    // VC phase: toggles every cycle, restarting from 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            polarity <= 1'b0;
        end else begin
            polarity <= ~polarity;
        end
    end

    logic                 rd_phase;
    logic [2:0]           head_vld;
    logic [PAC_WIDTH-1:0] head_dat [3];

    assign rd_phase = ~polarity;

    // Select the read-phase head of each input.
    always_comb begin
        head_vld = '0;
        for (int i = 0; i < 3; i++) begin
            head_vld[i] = !fifo_empty[i][rd_phase];
            head_dat[i] = fifo_head[i][rd_phase];
        end
    end

    // Each output has a primary requester (ring at ring outputs, cw at PE
    // output) and a secondary one (PE at ring outputs, ccw at PE output).
    logic [2:0]           req_pri;
    logic [2:0]           req_sec;
    logic [PAC_WIDTH-1:0] cand_pri [3];
    logic [PAC_WIDTH-1:0] cand_sec [3];

    // Routing decision and the packet each requester would deliver.
    always_comb begin
        req_pri = '0;
        req_sec = '0;
        req_pri[CW]  = head_vld[CW]  && (hop_of(head_dat[CW])  != 8'd0);
        req_sec[CW]  = head_vld[PE]  && !head_dat[PE][DIR_BIT];
        req_pri[CCW] = head_vld[CCW] && (hop_of(head_dat[CCW]) != 8'd0);
        req_sec[CCW] = head_vld[PE]  && head_dat[PE][DIR_BIT];
        req_pri[PE]  = head_vld[CW]  && (hop_of(head_dat[CW])  == 8'd0);
        req_sec[PE]  = head_vld[CCW] && (hop_of(head_dat[CCW]) == 8'd0);

        cand_pri[CW]  = dec_hop(head_dat[CW]);
        cand_sec[CW]  = head_dat[PE];
        cand_pri[CCW] = dec_hop(head_dat[CCW]);
        cand_sec[CCW] = head_dat[PE];
        cand_pri[PE]  = head_dat[CW];
        cand_sec[PE]  = head_dat[CCW];
    end

    logic [2:0] sel_sec;
    logic [2:0] grant;

`ifdef RING_ROUTER_RR_ARB_EN
    // 1 = secondary requester currently preferred on that output.
    logic [2:0] rr_ptr;

    // The winner of a contested grant drops to lowest priority next time.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else begin
            for (int o = 0; o < 3; o++) begin
                if (grant[o] && req_pri[o] && req_sec[o]) begin
                    rr_ptr[o] <= !sel_sec[o];
                end
            end
        end
    end
`endif

    // Arbitration per output; a grant needs a requester and downstream ready.
    always_comb begin
        sel_sec = '0;
        grant   = '0;
        for (int o = 0; o < 3; o++) begin
`ifdef RING_ROUTER_RR_ARB_EN
            sel_sec[o] = req_sec[o] && (!req_pri[o] || rr_ptr[o]);
`else
            sel_sec[o] = !req_pri[o];
`endif
            grant[o] = (req_pri[o] || req_sec[o]) && out_rdy[o];
        end
    end

    // Each head targets exactly one output, so at most one term per input is set.
    always_comb begin
        src_pop      = '0;
        src_pop[CW]  = (grant[CW]  && !sel_sec[CW])  || (grant[PE]  && !sel_sec[PE]);
        src_pop[CCW] = (grant[CCW] && !sel_sec[CCW]) || (grant[PE]  && sel_sec[PE]);
        src_pop[PE]  = (grant[CW]  && sel_sec[CW])   || (grant[CCW] && sel_sec[CCW]);
    end

    // Registered outputs: one-cycle valid pulse per packet, data held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld <= '0;
            for (int o = 0; o < 3; o++) begin
                out_dat[o] <= '0;
            end
        end else begin
            out_vld <= grant;
            for (int o = 0; o < 3; o++) begin
                if (grant[o]) begin
                    out_dat[o] <= sel_sec[o] ? cand_sec[o] : cand_pri[o];
                end
            end
        end
    end
endmodule

// File: tb/tb_ring_router_param.sv
// tb_ring_router_param: randomized and directed traffic through ring_router_param.
// A queue-based reference model predicts every output per cycle; a monitor pops and compares.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_ring_router_param;
    localparam int PW    = 64;
    localparam int DEPTH = 4;
`ifdef RING_ROUTER_RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic [2:0]    si;
    logic [2:0]    ro;
    logic [PW-1:0] di [3];
    logic          polarity;
    logic          cwri, ccwri, peri;
    logic          cwso, ccwso, peso;
    logic [PW-1:0] cwdo, ccwdo, pedo;

    ring_router_param #(.PAC_WIDTH(PW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .cwsi     (si[0]),
        .ccwsi    (si[1]),
        .pesi     (si[2]),
        .cwri     (cwri),
        .ccwri    (ccwri),
        .peri     (peri),
        .cwdi     (di[0]),
        .ccwdi    (di[1]),
        .pedi     (di[2]),
        .cwso     (cwso),
        .ccwso    (ccwso),
        .peso     (peso),
        .cwro     (ro[0]),
        .ccwro    (ro[1]),
        .pero     (ro[2]),
        .cwdo     (cwdo),
        .ccwdo    (ccwdo),
        .pedo     (pedo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    n_checks = 0;
    int    n_fail   = 0;
    string NM [3] = '{"cw", "ccw", "pe"};

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dat(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hop_of(input logic [PW-1:0] p);
        return p[PW-9 -: 8];
    endfunction

    function automatic logic [PW-1:0] mk(input logic dir, input logic [7:0] hop);
        logic [PW-1:0] p;
        p = {$urandom, $urandom};
        p[PW-2] = dir;
        p[PW-9 -: 8] = hop;
        return p;
    endfunction

    // Reference model: buffers as queues indexed input*2+phase, expected outputs per port.
    logic [PW-1:0] mq [6][$];
    logic [PW-1:0] eq [3][$];
    logic [PW-1:0] m_last [3];
    bit            m_pol;
    bit [2:0]      m_ptr;

    task automatic model_step();
        int            rp, wp, prim, sec, src;
        bit [2:0]      hv;
        bit            want_p, want_s;
        logic [PW-1:0] hd [3];
        logic [PW-1:0] pkt, junk;
        if (reset) begin
            for (int q = 0; q < 6; q++) mq[q].delete();
            for (int o = 0; o < 3; o++) m_last[o] = '0;
            m_pol = 1'b0;
            m_ptr = '0;
            return;
        end
        rp = m_pol ? 0 : 1;
        wp = m_pol ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            hv[i] = (mq[i*2+rp].size() != 0);
            hd[i] = hv[i] ? mq[i*2+rp][0] : '0;
        end
        for (int o = 0; o < 3; o++) begin
            // Contenders listed in default priority order.
            case (o)
                0: begin
                    prim = 0; sec = 2;
                    want_p = hv[0] && hop_of(hd[0]) != 0;
                    want_s = hv[2] && hd[2][PW-2] == 1'b0;
                end
                1: begin
                    prim = 1; sec = 2;
                    want_p = hv[1] && hop_of(hd[1]) != 0;
                    want_s = hv[2] && hd[2][PW-2] == 1'b1;
                end
                default: begin
                    prim = 0; sec = 1;
                    want_p = hv[0] && hop_of(hd[0]) == 0;
                    want_s = hv[1] && hop_of(hd[1]) == 0;
                end
            endcase
            if (!ro[o] || !(want_p || want_s)) continue;
            if (want_p && want_s) begin
                src = (RR && m_ptr[o]) ? sec : prim;
                if (RR) m_ptr[o] = (src == prim);
            end else begin
                src = want_p ? prim : sec;
            end
            pkt = hd[src];
            if (o != 2 && src != 2) pkt[PW-9 -: 8] = hop_of(pkt) - 8'd1;
            junk = mq[src*2+rp].pop_front();
            eq[o].push_back(pkt);
            m_last[o] = pkt;
        end
        for (int i = 0; i < 3; i++) begin
            if (si[i] && mq[i*2+wp].size() < DEPTH) mq[i*2+wp].push_back(di[i]);
        end
        m_pol = !m_pol;
    endtask

    initial begin
        m_pol = 1'b0;
        m_ptr = '0;
        for (int o = 0; o < 3; o++) m_last[o] = '0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compare phase, readiness and outputs against the model each cycle.
    logic [2:0]    rdy_v, so_v;
    logic [PW-1:0] do_v [3];
    logic [PW-1:0] exp_d;
    bit            exp_v;
    initial begin
        forever begin
            @(negedge clk);
            rdy_v   = {peri, ccwri, cwri};
            so_v    = {peso, ccwso, cwso};
            do_v[0] = cwdo;
            do_v[1] = ccwdo;
            do_v[2] = pedo;
            check_bit("polarity", polarity, m_pol);
            for (int i = 0; i < 3; i++) begin
                check_bit({"ready_", NM[i]}, rdy_v[i],
                          !reset && (mq[i*2 + (m_pol ? 1 : 0)].size() < DEPTH));
            end
            for (int o = 0; o < 3; o++) begin
                exp_v = (eq[o].size() != 0);
                check_bit({"valid_", NM[o]}, so_v[o], exp_v);
                if (exp_v) begin
                    exp_d = eq[o].pop_front();
                    check_dat({"data_", NM[o]}, do_v[o], exp_d);
                end else begin
                    check_dat({"hold_", NM[o]}, do_v[o], m_last[o]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        si = '0;
        repeat (n) tick();
    endtask

    task automatic rand_cycle();
        logic [7:0] h;
        for (int i = 0; i < 3; i++) begin
            case ($urandom % 4)
                0:       h = 8'd0;
                1:       h = 8'd1;
                2:       h = 8'd2;
                default: h = 8'($urandom);
            endcase
            si[i] = ($urandom % 3) != 0;
            di[i] = mk(1'($urandom % 2), h);
            ro[i] = ($urandom % 4) != 0;
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        si    = '0;
        ro    = 3'b111;
        for (int i = 0; i < 3; i++) di[i] = '0;
        repeat (3) tick();
        reset = 1'b0;

        // cw stream, hop 1: forwarded on cw with hop 0
        for (int k = 0; k < 10; k++) begin
            si = 3'b001; di[0] = mk(1'b0, 8'd1); tick();
        end
        idle(4);

        // ccw stream, hop 0: delivered to PE
        for (int k = 0; k < 8; k++) begin
            si = 3'b010; di[1] = mk(1'b1, 8'd0); tick();
        end
        idle(4);

        // PE stream alternating direction
        for (int k = 0; k < 8; k++) begin
            si = 3'b100; di[2] = mk(1'(k % 2), 8'd1); tick();
        end
        idle(4);

        // cw and ccw contend for PE output
        for (int k = 0; k < 4; k++) begin
            si = 3'b011; di[0] = mk(1'b0, 8'd0); di[1] = mk(1'b1, 8'd0); tick();
        end
        idle(6);

        // cw output stalled: buffers fill, ready drops, then drain in order
        ro = 3'b110;
        for (int k = 0; k < 12; k++) begin
            si = 3'b001; di[0] = mk(1'b0, 8'd1); tick();
        end
        si = '0;
        repeat (3) tick();
        ro = 3'b111;
        idle(12);

        // randomized traffic with random backpressure
        for (int k = 0; k < 1500; k++) rand_cycle();

        // reset with buffers full and outputs stalled
        ro = 3'b000;
        for (int k = 0; k < 6; k++) begin
            si = 3'b111;
            for (int i = 0; i < 3; i++) di[i] = mk(1'($urandom % 2), 8'($urandom % 3));
            tick();
        end
        si = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ro = 3'b111;
        idle(10);

        // clean restart
        for (int k = 0; k < 60; k++) rand_cycle();
        ro = 3'b111;
        idle(20);
        @(negedge clk);
        #1;
        for (int o = 0; o < 3; o++) begin
            check_bit({"drained_", NM[o]}, eq[o].size() == 0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ring_router_param.md
RING_ROUTER_PARAM -- requirements
Module: ring_router_param

Interface
REQ-001 The block SHALL have parameter PAC_WIDTH, default 64, packet width in bits (minimum 24).
REQ-002 The block SHALL have parameter DEPTH, default 4, entries per VC buffer per input port (power of 2, minimum 2).
REQ-003 The packet fields SHALL be: bit PAC_WIDTH-1 vc, bit PAC_WIDTH-2 dir (0 = cw, 1 = ccw), bits [PAC_WIDTH-9:PAC_WIDTH-16] hop, remaining bits payload.
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port polarity  output  1  VC phase; toggles every cycle.
REQ-007 Ports cwsi, ccwsi, pesi  input  1 each  send strobe from cw ring, ccw ring, PE.
REQ-008 Ports cwri, ccwri, peri  output  1 each  ready to accept on that input.
REQ-009 Ports cwdi, ccwdi, pedi  input  PAC_WIDTH each  input packet.
REQ-010 Ports cwso, ccwso, peso  output  1 each  output packet valid, one-cycle pulse per packet.
REQ-011 Ports cwro, ccwro, pero  input  1 each  downstream ready.
REQ-012 Ports cwdo, ccwdo, pedo  output  PAC_WIDTH each  output packet, registered.

Function
REQ-013 Each input SHALL own two FIFOs, buf[0] and buf[1], each DEPTH deep; external side uses buf[polarity], internal side uses buf[~polarity].
REQ-014 Input xri SHALL equal !full(buf[polarity]) && !reset, combinationally.
REQ-015 On a rising edge with xsi && xri, xdi SHALL be written to buf[polarity] of that input; the vc bit is carried unchanged and never used for selection.
REQ-016 Each cycle the router SHALL examine the heads of buf[~polarity] on all three inputs.
REQ-017 Routing: ring input with hop == 0 goes to PE output; ring input with hop != 0 goes to the same-direction ring output with hop decremented by 1; PE input goes to the cw output if dir = 0 and the ccw output if dir = 1, with hop unchanged.
REQ-018 An output SHALL load a packet only when its xro = 1 at that edge; it then sets xso <= 1 and xdo <= the packet, and pops the source FIFO.
REQ-019 Each output SHALL otherwise set xso <= 0 and hold xdo at its last value.
REQ-020 Contention: cw output (cw ring vs PE), ccw output (ccw ring vs PE) and PE output (cw vs ccw) SHALL each grant at most one source per cycle, arbitrated per REQ-028/029.
REQ-021 A losing head SHALL remain in its FIFO, unmodified, until a later cycle of the same VC phase.
REQ-022 Minimum latency SHALL be 1 cycle: a packet written to buf[p] at edge t appears on xso/xdo after edge t+1 (when polarity = ~p), provided the output is free and xro = 1.
REQ-023 Hop decrement SHALL be an 8-bit subtraction; hop == 0 is never decremented, so no wrap occurs.
REQ-024 Write and pop on the same FIFO in one cycle cannot occur, because write and read phases are disjoint; a full FIFO SHALL deassert xri with no write and no loss.

Reset
REQ-025 While reset = 1 at an edge: polarity <= 0, all FIFOs empty, cwso/ccwso/peso <= 0, cwdo/ccwdo/pedo <= 0, arbiter pointers <= ring-preferred, and all xri = 0.
REQ-026 After reset deasserts, polarity SHALL toggle every cycle starting from 0, and xri SHALL be 1 in the first post-reset cycle.
REQ-027 Reset asserted mid-operation SHALL discard all buffered and in-flight packets at that edge.

Configuration
REQ-028 With macro RING_ROUTER_RR_ARB_EN defined, each contended output SHALL use a 1-bit round-robin pointer: the winner gets lowest priority next, and the pointer updates only on a grant while both requesters are present.
REQ-029 Without RING_ROUTER_RR_ARB_EN, fixed priority SHALL apply: ring input over PE at the ring outputs, and cw over ccw at the PE output.

Verification
REQ-030 After reset, cwsi = 1 streams 10 packets with hop = 1, dir = 0 and all ro = 1 -> each packet exits cwdo 1 cycle later with hop = 0, payload identical, no loss.
REQ-031 ccwsi = 1 streams packets with hop = 0 -> each appears on pedo with peso pulse 1 cycle later; cwso and ccwso stay 0.
REQ-032 pesi = 1 with dir alternating 0/1 and hop = 1 -> packets alternate between cwdo and ccwdo with hop = 1, in order.
REQ-033 cw and ccw both inject hop = 0 on the same edge -> pedo delivers both on consecutive same-phase cycles, with winner order per RR_ARB_EN setting.
REQ-034 cwro = 0 held while cwsi streams hop = 1 with DEPTH = 4 -> cwri drops after 4 writes to that phase buffer; after cwro = 1, all 4 drain in FIFO order.
REQ-035 Reset asserted with buffers non-empty -> all so = 0 and do = 0 next cycle, polarity = 0, and no stale packets appear afterwards.
